ddr3_sniff_reader: RTL

DDR3_SNIFF_READER -- requirements
Module: ddr3_sniff_reader

---
 rtl/ddr3_sniff_pkg.sv | 12 +
 rtl/ddr3_sniff_fifo.sv | 51 +++++
 rtl/ddr3_sniff_reader.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ddr3_sniff_pkg.sv
// Shared constants and FSM state type for the DDR3 sniff reader.
package ddr3_sniff_pkg;

  localparam int DATA_W = 288;
  localparam int MASK_W = 36;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

endpackage

// File: rtl/ddr3_sniff_fifo.sv
// Synchronous read-data FIFO; DEPTH must be a power of two. The level output
// feeds the reader's issue-credit calculation.
module ddr3_sniff_fifo
  import ddr3_sniff_pkg::*;
#(
  parameter int DEPTH = 16
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        push_data_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        pop_data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic              do_push, do_pop;

  assign do_push = push_i && (level_q != LVL_W'(DEPTH));
  assign do_pop  = pop_i && (level_q != '0);

  // NOTE: the storage array has no reset; pointers and level alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data_i;
  end

  // NOTE: sequential state uses <= so every register sees pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  assign pop_data_o = mem[rd_ptr_q];
  assign empty_o    = (level_q == '0);
  assign level_o    = level_q;

endmodule

// File: rtl/ddr3_sniff_reader.sv
// Issues credit-limited DDR3 read commands and buffers the returned beats.
// Optional macro DDR3_SNIFF_ERR_EN enables the stray-beat error counter.
module ddr3_sniff_reader
  import ddr3_sniff_pkg::*;
#(
  parameter int          FIFO_DEPTH    = 16,
  parameter logic [31:0] ADDR_STEP     = 32'd8,
  parameter int          BEATS_PER_CMD = 2
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       start_addr,
  input  logic [7:0]        cmd_count,
  output logic              busy,
  output logic              done,
  output logic [31:0]       ddr_addr,
  output logic [2:0]        ddr_cmd,
  output logic              ddr_en,
  output logic              ddr_wdf_wren,
  output logic              ddr_wdf_end,
  output logic [DATA_W-1:0] ddr_wdf_data,
  output logic [MASK_W-1:0] ddr_wdf_mask,
  input  logic              ddr_rdy,
  input  logic              ddr_wdf_rdy,
  input  logic [DATA_W-1:0] ddr_rd_data,
  input  logic              ddr_rd_data_valid,
  input  logic              ddr_rd_data_end,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       err_count
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CR_W  = LVL_W + 1;

  state_e           state_q;
  logic             busy_q, done_q;
  logic [31:0]      addr_q;
  logic [7:0]       remain_q;
  logic [LVL_W-1:0] outstanding_q, outstanding_d;
  logic [LVL_W-1:0] fifo_level;
  logic [CR_W-1:0]  committed;
  logic             fifo_empty, accept, push, stray, pop;
  logic             unused_inputs;

  // Issue only while the FIFO can absorb every promised beat plus this command's.
  assign committed = CR_W'(fifo_level) + CR_W'(outstanding_q);
  assign ddr_en    = (state_q == ISSUE) &&
                     (committed + CR_W'(BEATS_PER_CMD) <= CR_W'(FIFO_DEPTH));
  assign accept    = ddr_en && ddr_rdy;
  assign push      = ddr_rd_data_valid && (outstanding_q != '0);
  assign stray     = ddr_rd_data_valid && (outstanding_q == '0);
  assign pop       = !fifo_empty && out_ready;

  // NOTE: default assignment first, so no path leaves outstanding_d unassigned (no latch).
  always_comb begin
    outstanding_d = outstanding_q;
    if (accept) outstanding_d = outstanding_d + LVL_W'(BEATS_PER_CMD);
    if (push)   outstanding_d = outstanding_d - LVL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      addr_q        <= '0;
      remain_q      <= '0;
      outstanding_q <= '0;
    end else begin
      done_q        <= 1'b0;
      outstanding_q <= outstanding_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (cmd_count != 8'd0) begin
              addr_q   <= start_addr;
              remain_q <= cmd_count;
              busy_q   <= 1'b1;
              state_q  <= ISSUE;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (accept) begin
            addr_q   <= addr_q + ADDR_STEP;
            remain_q <= remain_q - 8'd1;
            if (remain_q == 8'd1) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (outstanding_d == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  ddr3_sniff_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (ddr_rd_data),
    .pop_i       (pop),
    .pop_data_o  (out_data),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level)
  );

`ifdef DDR3_SNIFF_ERR_EN
  logic [15:0] err_q;
  always_ff @(posedge clk) begin
    if (rst)                            err_q <= '0;
    else if (stray && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
  end
  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

  assign busy         = busy_q;
  assign done         = done_q;
  assign ddr_addr     = addr_q;
  assign ddr_cmd      = CMD_READ;
  assign ddr_wdf_wren = 1'b0;
  assign ddr_wdf_end  = 1'b0;
  assign ddr_wdf_data = '0;
  assign ddr_wdf_mask = '1;
  assign out_valid    = !fifo_empty;

  // End-of-burst and write-ready are informational; stray feeds only the optional counter.
  assign unused_inputs = &{1'b0, ddr_wdf_rdy, ddr_rd_data_end, stray};

endmodule
